// File: rtl/run_sequencer_if.sv
// run_sequencer_if
// Groups the host start handshake, operand load stream, data-memory port,
// core control and run results of run_sequencer into one bundle.
//   master : host/environment side (drives req, load stream, memory read data,
//            core_done)
//   slave  : run_sequencer side (drives load_ready, memory write port,
//            core_reset and the run results)
interface run_sequencer_if;
  logic        req;
  logic [3:0]  load_count;
  logic [7:0]  load_data;
  logic        load_valid;
  logic        load_ready;

  logic        mem_wr_en;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wr_data;
  logic [7:0]  mem_rd_data;

  logic        core_reset;
  logic        core_done;

  logic [7:0]  result;
  logic        ack;
  logic        timeout;
  logic [15:0] cycles;

  modport master (
    output req, load_count, load_data, load_valid, mem_rd_data, core_done,
    input  load_ready, mem_wr_en, mem_addr, mem_wr_data, core_reset,
           result, ack, timeout, cycles
  );

  modport slave (
    input  req, load_count, load_data, load_valid, mem_rd_data, core_done,
    output load_ready, mem_wr_en, mem_addr, mem_wr_data, core_reset,
           result, ack, timeout, cycles
  );
endinterface

// File: rtl/run_sequencer.sv
// run_sequencer
// Runs one job on a small processor core: preloads up to 8 operand bytes into
// data memory, releases the core from reset until it reports done (or a cycle
// limit expires), reads the result byte back from memory and presents it to
// the host with a four-phase req/ack handshake.
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : run_sequencer_if.slave (host handshake, load stream, memory port,
//          core control, results)
// Parameters:
//   TIMEOUT     : core-run cycle limit; 0 disables the limit
//   RESULT_ADDR : data-memory address holding the result byte
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | core held in reset, waiting for req
// S_LOAD | accepting operand bytes, each written to mem[index]
// S_RUN  | core released, counting cycles until done or timeout
// S_READ | core back in reset, result byte read from RESULT_ADDR
// S_ACK  | results presented, waiting for req to drop
module run_sequencer #(
  parameter logic [15:0] TIMEOUT     = 16'd1000,
  parameter logic [7:0]  RESULT_ADDR = 8'd0
) (
  input  logic             clk,
  input  logic             rst,
  run_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_READ,
    S_ACK
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [3:0]  count_q;
  logic [3:0]  idx_q;
  logic [15:0] cycles_q;
  logic        timeout_q;
  logic [7:0]  result_q;
  logic        first_q;

  logic [15:0] cycles_nxt;
  logic        last_byte;
  logic        done_seen;
  logic        hit_limit;
  logic [3:0]  count_clamped;

  logic        load_ready;
  logic        mem_wr_en;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wr_data;
  logic        core_reset;
  logic        ack;

  assign count_clamped = (bus.load_count > 4'd8) ? 4'd8 : bus.load_count;
  assign last_byte     = (idx_q == (count_q - 4'd1));
  assign cycles_nxt    = (cycles_q == 16'hFFFF) ? cycles_q : (cycles_q + 16'd1);
  // The core is still coming out of reset in its first RUN cycle, so a done
  // flag seen then is stale.
  assign done_seen     = bus.core_done && !first_q;
  // Compared against the post-increment count so the limit lands on the
  // cycle in which Cycles becomes TIMEOUT.
  assign hit_limit     = (TIMEOUT != 16'd0) && (cycles_nxt == TIMEOUT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    load_ready  = 1'b0;
    mem_wr_en   = 1'b0;
    mem_addr    = 8'd0;
    mem_wr_data = 8'd0;
    core_reset  = 1'b1;
    ack         = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.req) begin
          state_nxt = (bus.load_count == 4'd0) ? S_RUN : S_LOAD;
        end
      end
      S_LOAD: begin
        load_ready = 1'b1;
        mem_addr   = {4'd0, idx_q};
        if (bus.load_valid) begin
          mem_wr_en   = 1'b1;
          mem_wr_data = bus.load_data;
          if (last_byte) begin
            state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        core_reset = 1'b0;
        if (done_seen || hit_limit) begin
          state_nxt = S_READ;
        end
      end
      S_READ: begin
        mem_addr  = RESULT_ADDR;
        state_nxt = S_ACK;
      end
      S_ACK: begin
        ack = 1'b1;
        if (!bus.req) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= 4'd0;
      idx_q     <= 4'd0;
      cycles_q  <= 16'd0;
      timeout_q <= 1'b0;
      result_q  <= 8'd0;
      first_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req) begin
            count_q   <= count_clamped;
            idx_q     <= 4'd0;
            cycles_q  <= 16'd0;
            timeout_q <= 1'b0;
            first_q   <= 1'b1;
          end
        end
        S_LOAD: begin
          if (bus.load_valid) begin
            idx_q <= idx_q + 4'd1;
          end
        end
        S_RUN: begin
          cycles_q <= cycles_nxt;
          first_q  <= 1'b0;
          // A real done in the limit cycle takes priority over the timeout.
          if (hit_limit && !done_seen) begin
            timeout_q <= 1'b1;
          end
        end
        S_READ: begin
          result_q <= bus.mem_rd_data;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.load_ready  = load_ready;
  assign bus.mem_wr_en   = mem_wr_en;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_wr_data = mem_wr_data;
  assign bus.core_reset  = core_reset;
  assign bus.ack         = ack;
  assign bus.result      = result_q;
  assign bus.timeout     = timeout_q;
  assign bus.cycles      = cycles_q;

endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer
// Drives run_sequencer jobs (directed corner cases followed by randomized
// jobs) and compares every cycle against a phase-level model of a job:
// n operand bytes, then min(max(d,2), TIMEOUT) run cycles, then one read
// cycle and the acknowledge.
module tb_run_sequencer;
  localparam logic [15:0] TMO   = 16'd10;
  localparam logic [7:0]  RADDR = 8'd0;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] mem     [256] = '{default: 8'h00};
  logic [7:0] ref_mem [256] = '{default: 8'h00};
  logic [7:0] stim    [8];

  run_sequencer_if bus ();

  run_sequencer #(.TIMEOUT(TMO), .RESULT_ADDR(RADDR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.mem_rd_data = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wr_data;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // gap_mode: 0 = valid every load cycle, 1 = random gaps, 2 = alternate
  // abort_at: >0 pulses reset after that many run cycles
  task automatic do_run(input int cnt, input int d, input int gap_mode, input int abort_at);
    int          n, sent, run_cyc, post, load_cyc, eff_d;
    logic [15:0] exp_cyc;
    logic        exp_to, in_load, in_run, finished;
    logic [7:0]  exp_res;
    n = (cnt > 8) ? 8 : cnt;
    for (int i = 0; i < n; i++) ref_mem[i] = stim[i];
    exp_res = ref_mem[RADDR];
    eff_d = (d < 2) ? 2 : d;
    if (eff_d <= int'(TMO)) begin
      exp_cyc = 16'(eff_d);
      exp_to  = 1'b0;
    end else begin
      exp_cyc = TMO;
      exp_to  = 1'b1;
    end
    sent = 0; run_cyc = 0; post = 0; load_cyc = 0; finished = 1'b0;
    bus.req        = 1'b1;
    bus.load_count = cnt[3:0];
    for (int c = 0; c < 300 && !finished; c++) begin
      @(negedge clk);
      in_load = (sent < n);
      in_run  = !in_load && (run_cyc < int'(exp_cyc));
      if (!in_load && !in_run) post++;
      case (gap_mode)
        1:       bus.load_valid = in_load && ($urandom_range(0, 1) == 1);
        2:       bus.load_valid = in_load && (load_cyc % 2 == 0);
        default: bus.load_valid = in_load;
      endcase
      bus.load_data = in_load ? stim[sent] : 8'h00;
      bus.core_done = in_run && (run_cyc + 1 >= d);
      #1;
      check_val("load_ready", bus.load_ready, in_load);
      check_val("mem_wr_en", bus.mem_wr_en, in_load && bus.load_valid);
      if (in_load && bus.load_valid) begin
        check_val("wr_addr", bus.mem_addr, sent);
        check_val("wr_data", bus.mem_wr_data, stim[sent]);
        sent++;
      end
      if (in_load) load_cyc++;
      check_val("core_reset", bus.core_reset, !in_run);
      check_val("ack", bus.ack, post == 2);
      if (post == 1) check_val("read_addr", bus.mem_addr, RADDR);
      if (in_run) run_cyc++;
      if (abort_at > 0 && in_run && run_cyc == abort_at) begin
        rst = 1'b1;
        #1;
        check_val("abort_core_reset", bus.core_reset, 1'b1);
        check_val("abort_ack", bus.ack, 1'b0);
        check_val("abort_cycles", bus.cycles, 16'd0);
        check_val("abort_timeout", bus.timeout, 1'b0);
        check_val("abort_result", bus.result, 8'd0);
        check_val("abort_wr_en", bus.mem_wr_en, 1'b0);
        bus.req = 1'b0;
        bus.core_done = 1'b0;
        @(negedge clk);
        #1;
        check_val("abort_hold_core_reset", bus.core_reset, 1'b1);
        rst = 1'b0;
        return;
      end
      if (post == 2) finished = 1'b1;
    end
    if (!finished) check_val("run_budget", 1'b0, 1'b1);
    bus.load_valid = 1'b0;
    bus.core_done  = 1'b0;
    check_val("write_count", sent, n);
    check_val("result", bus.result, exp_res);
    check_val("cycles", bus.cycles, exp_cyc);
    check_val("timeout", bus.timeout, exp_to);
    check_val("ack_mem_addr", bus.mem_addr, 8'd0);
    check_val("ack_mem_wr_data", bus.mem_wr_data, 8'd0);
    @(negedge clk);
    #1;
    check_val("ack_hold", bus.ack, 1'b1);
    check_val("ack_hold_result", bus.result, exp_res);
    bus.req = 1'b0;
    @(negedge clk);
    #1;
    check_val("idle_ack", bus.ack, 1'b0);
    check_val("idle_core_reset", bus.core_reset, 1'b1);
    check_val("idle_load_ready", bus.load_ready, 1'b0);
    check_val("idle_result", bus.result, exp_res);
    check_val("idle_cycles", bus.cycles, exp_cyc);
    check_val("idle_timeout", bus.timeout, exp_to);
  endtask

  initial begin
    rst            = 1'b1;
    bus.req        = 1'b0;
    bus.load_count = 4'd0;
    bus.load_data  = 8'd0;
    bus.load_valid = 1'b0;
    bus.core_done  = 1'b0;
    #1;
    check_val("rst_core_reset", bus.core_reset, 1'b1);
    check_val("rst_ack", bus.ack, 1'b0);
    check_val("rst_load_ready", bus.load_ready, 1'b0);
    check_val("rst_wr_en", bus.mem_wr_en, 1'b0);
    check_val("rst_cycles", bus.cycles, 16'd0);
    check_val("rst_result", bus.result, 8'd0);
    check_val("rst_timeout", bus.timeout, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    stim[0] = 8'd1;
    do_run(1, 3, 0, 0);
    stim[0] = 8'd4; stim[1] = 8'd3;
    do_run(2, 5, 2, 0);
    do_run(0, 4, 0, 0);
    do_run(0, 100, 0, 0);
    stim[0] = 8'h5A;
    do_run(1, 10, 0, 0);
    do_run(0, 11, 0, 0);
    stim[0] = 8'hC3;
    do_run(1, 1, 0, 0);
    for (int i = 0; i < 8; i++) stim[i] = 8'(i * 17 + 9);
    do_run(12, 6, 1, 0);

    stim[0] = 8'(($urandom_range(0, 254)) + 1);
    do_run(1, 50, 0, 4);
    stim[0] = 8'd1;
    do_run(1, 3, 0, 0);

    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 8; i++) stim[i] = 8'($urandom_range(0, 255));
      do_run(int'($urandom_range(0, 15)), int'($urandom_range(1, 14)), 1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
